// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the host-command processor.
// Holds the opcode values, the ACK/NAK reply bytes, the command FSM state
// encoding, and the helper that gives the argument count for each opcode.
package serial_cmd_pkg;

    localparam logic [7:0] OP_VERSION = 8'h00;
    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] OP_HIST    = 8'h03;
    localparam logic [7:0] OP_CNT     = 8'h04;
    localparam logic [7:0] OP_PHASE   = 8'h05;

    localparam logic [7:0] ACK_BYTE   = 8'hAC;
    localparam logic [7:0] NAK_BYTE   = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARGS,
        S_EXEC,
        S_PHASE,
        S_SEND,
        S_WAITTX
    } state_t;

    // Number of argument bytes that follow each opcode; unknown opcodes take
    // none so that they fall straight through to the NAK reply.
    function automatic logic [1:0] args_for(input logic [7:0] op);
        case (op)
            OP_WRITE: return 2'd2;
            OP_READ:  return 2'd1;
            OP_PHASE: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pll_phase_stepper.sv
// PLL phase-step sequencer.
// On a start pulse it raises phase_step, then toggles scanclk every 16 clk
// for 8 half-periods, drops phase_step together with the 6th toggle, and
// pulses done for one cycle together with the 8th toggle.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   start        - one-cycle request (ignored while a sequence is running)
//   done         - one-cycle pulse when the sequence has finished
//   phase_step   - PLL phase-step request
//   scanclk      - PLL scan clock
module pll_phase_stepper (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done,
    output logic phase_step,
    output logic scanclk
);

    logic       busy_q, busy_d;
    logic [3:0] div_q, div_d;
    logic [2:0] tog_q, tog_d;
    logic       done_q, done_d;
    logic       step_q, step_d;
    logic       sclk_q, sclk_d;

    // div counts 16 clocks per half-period; tog counts completed toggles.
    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        tog_d  = tog_q;
        done_d = 1'b0;
        step_d = step_q;
        sclk_d = sclk_q;
        if (start && !busy_q) begin
            busy_d = 1'b1;
            step_d = 1'b1;
            div_d  = '0;
            tog_d  = '0;
            sclk_d = 1'b0;
        end else if (busy_q) begin
            div_d = div_q + 4'd1;
            if (div_q == 4'd15) begin
                sclk_d = ~sclk_q;
                tog_d  = tog_q + 3'd1;
                if (tog_q == 3'd5) begin
                    step_d = 1'b0;
                end
                if (tog_q == 3'd7) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            div_q  <= '0;
            tog_q  <= '0;
            done_q <= 1'b0;
            step_q <= 1'b0;
            sclk_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            tog_q  <= tog_d;
            done_q <= done_d;
            step_q <= step_d;
            sclk_q <= sclk_d;
        end
    end

    assign done       = done_q;
    assign phase_step = step_q;
    assign scanclk    = sclk_q;

endmodule

// File: rtl/serial_cmd_engine.sv
// Host-command processor for the trigger board.
// Decodes opcode/argument bytes from the UART receiver, owns the
// configuration register file, and streams reply bytes to the UART
// transmitter from a snapshot buffer loaded in the EXEC cycle.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   rx_ready, rx_data     - received byte strobe and data
//   tx_busy               - transmitter busy
//   tx_start, tx_data     - one-cycle send strobe and byte
//   histos, counters      - per-board histogram / clock counter inputs
//   trig_fired            - per-board last trigger byte
//   cfg_regs              - configuration registers, reg r at [r*8 +: 8]
//   reset_hist, reset_out - one-cycle pulses after the matching snapshot
//   phase_sel, phase_updown, phase_step, scanclk - PLL phase control
module serial_cmd_engine #(
    parameter int         NBOARDS = 8,
    parameter int         HIST_W  = 32,
    parameter int         CNT_W   = 56,
    parameter int         NREG    = 16,
    parameter int         TIMEOUT = 1_000_000,
    parameter logic [7:0] VERSION = 8'd9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    input  logic [NBOARDS*HIST_W-1:0] histos,
    input  logic [NBOARDS*CNT_W-1:0]  counters,
    input  logic [NBOARDS*8-1:0]      trig_fired,
    output logic [NREG*8-1:0]         cfg_regs,
    output logic                      reset_hist,
    output logic                      reset_out,
    output logic [2:0]                phase_sel,
    output logic                      phase_updown,
    output logic                      phase_step,
    output logic                      scanclk
);
    import serial_cmd_pkg::*;

    localparam int HIST_BYTES = NBOARDS * HIST_W / 8;
    localparam int CNT_BYTES  = CNT_W / 8;
    localparam int CNT_REPLY  = NBOARDS * (CNT_BYTES + 1);
    localparam int MAX_LEN    = (HIST_BYTES > CNT_REPLY) ? HIST_BYTES : CNT_REPLY;
    localparam int IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_W      = $clog2(TIMEOUT + 1);

    // Coincidence window in reg 0, dead time in reg 1, everything else clear.
    localparam logic [NREG*8-1:0] CFG_RESET = {{(NREG-2)*8{1'b0}}, 8'd50, 8'd20};

    state_t               state_q, state_d;
    logic [7:0]           op_q, op_d;
    logic [7:0]           arg0_q, arg0_d;
    logic [7:0]           arg1_q, arg1_d;
    logic [1:0]           arg_cnt_q, arg_cnt_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [NREG*8-1:0]    cfg_q, cfg_d;
    logic [MAX_LEN*8-1:0] reply_q, reply_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 reset_hist_q, reset_hist_d;
    logic                 reset_out_q, reset_out_d;
    logic [2:0]           phase_sel_q, phase_sel_d;
    logic                 phase_updown_q, phase_updown_d;

    logic                 step_start;
    logic                 step_done;
    logic [7:0]           addr_mod;
    logic [MAX_LEN*8-1:0] hist_img;
    logic [MAX_LEN*8-1:0] cnt_img;

    // Register addresses wrap modulo NREG (NREG is a power of two).
    assign addr_mod = arg0_q & 8'(NREG - 1);

    // Histogram reply image: boards are already packed little-endian.
    always_comb begin
        hist_img = '0;
        hist_img[HIST_BYTES*8-1:0] = histos;
    end

    // Counter reply image: each board contributes its counter bytes LSB
    // first followed by its trigger byte.
    always_comb begin
        cnt_img = '0;
        for (int b = 0; b < NBOARDS; b++) begin
            for (int k = 0; k < CNT_BYTES; k++) begin
                cnt_img[(b*(CNT_BYTES+1)+k)*8 +: 8] = counters[b*CNT_W + k*8 +: 8];
            end
            cnt_img[(b*(CNT_BYTES+1)+CNT_BYTES)*8 +: 8] = trig_fired[b*8 +: 8];
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        arg0_d         = arg0_q;
        arg1_d         = arg1_q;
        arg_cnt_d      = arg_cnt_q;
        timer_d        = timer_q;
        cfg_d          = cfg_q;
        reply_d        = reply_q;
        idx_d          = idx_q;
        last_d         = last_q;
        tx_start_d     = 1'b0;
        tx_data_d      = tx_data_q;
        reset_hist_d   = 1'b0;
        reset_out_d    = 1'b0;
        phase_sel_d    = phase_sel_q;
        phase_updown_d = phase_updown_q;
        step_start     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_ready) begin
                    op_d      = rx_data;
                    arg_cnt_d = '0;
                    timer_d   = '0;
                    state_d   = (args_for(rx_data) == 2'd0) ? S_EXEC : S_ARGS;
                end
            end
            S_ARGS: begin
                if (rx_ready) begin
                    if (arg_cnt_q == 2'd0) begin
                        arg0_d = rx_data;
                    end else begin
                        arg1_d = rx_data;
                    end
                    // The register write lands as the data byte is accepted.
                    if (op_q == OP_WRITE && arg_cnt_q == 2'd1) begin
                        cfg_d[addr_mod*8 +: 8] = rx_data;
                    end
                    arg_cnt_d = arg_cnt_q + 2'd1;
                    timer_d   = '0;
                    if (arg_cnt_q + 2'd1 == args_for(op_q)) begin
                        state_d = S_EXEC;
                    end
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    reply_d       = '0;
                    reply_d[7:0]  = NAK_BYTE;
                    idx_d         = '0;
                    last_d        = '0;
                    state_d       = S_SEND;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_EXEC: begin
                reply_d = '0;
                idx_d   = '0;
                last_d  = '0;
                state_d = S_SEND;
                case (op_q)
                    OP_VERSION: reply_d[7:0] = VERSION;
                    OP_WRITE:   reply_d[7:0] = ACK_BYTE;
                    OP_READ:    reply_d[7:0] = cfg_q[addr_mod*8 +: 8];
                    OP_HIST: begin
                        reply_d      = hist_img;
                        last_d       = IDX_W'(HIST_BYTES - 1);
                        reset_hist_d = 1'b1;
                    end
                    OP_CNT: begin
                        reply_d     = cnt_img;
                        last_d      = IDX_W'(CNT_REPLY - 1);
                        reset_out_d = 1'b1;
                    end
                    OP_PHASE: begin
                        phase_sel_d    = arg0_q[2:0];
                        phase_updown_d = arg1_q[0];
                        step_start     = 1'b1;
                        reply_d[7:0]   = ACK_BYTE;
                        state_d        = S_PHASE;
                    end
                    default:    reply_d[7:0] = NAK_BYTE;
                endcase
            end
            S_PHASE: begin
                if (step_done) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = reply_q[idx_q*8 +: 8];
                    tx_start_d = 1'b1;
                    state_d    = S_WAITTX;
                end
            end
            // One dead cycle so the transmitter can raise tx_busy before
            // the next byte is considered.
            S_WAITTX: begin
                if (idx_q == last_q) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_SEND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            arg0_q         <= '0;
            arg1_q         <= '0;
            arg_cnt_q      <= '0;
            timer_q        <= '0;
            cfg_q          <= CFG_RESET;
            reply_q        <= '0;
            idx_q          <= '0;
            last_q         <= '0;
            tx_start_q     <= 1'b0;
            tx_data_q      <= '0;
            reset_hist_q   <= 1'b0;
            reset_out_q    <= 1'b0;
            phase_sel_q    <= '0;
            phase_updown_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            arg0_q         <= arg0_d;
            arg1_q         <= arg1_d;
            arg_cnt_q      <= arg_cnt_d;
            timer_q        <= timer_d;
            cfg_q          <= cfg_d;
            reply_q        <= reply_d;
            idx_q          <= idx_d;
            last_q         <= last_d;
            tx_start_q     <= tx_start_d;
            tx_data_q      <= tx_data_d;
            reset_hist_q   <= reset_hist_d;
            reset_out_q    <= reset_out_d;
            phase_sel_q    <= phase_sel_d;
            phase_updown_q <= phase_updown_d;
        end
    end

    pll_phase_stepper u_stepper (
        .clk        (clk),
        .reset      (reset),
        .start      (step_start),
        .done       (step_done),
        .phase_step (phase_step),
        .scanclk    (scanclk)
    );

    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign cfg_regs     = cfg_q;
    assign reset_hist   = reset_hist_q;
    assign reset_out    = reset_out_q;
    assign phase_sel    = phase_sel_q;
    assign phase_updown = phase_updown_q;

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Self-checking bench for serial_cmd_engine: a table of single-reply
// commands, randomized commands checked against a register-file model,
// and hand-written sequences for snapshots, timeout, phase stepping,
// transmitter back-pressure and mid-reply reset.
module tb_serial_cmd_engine;

    localparam int         NB  = 8;
    localparam int         HW  = 32;
    localparam int         CW  = 56;
    localparam int         NR  = 16;
    localparam int         TO  = 300;
    localparam logic [7:0] VER = 8'd9;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx_ready = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [NB*HW-1:0]  histos = '0;
    logic [NB*CW-1:0]  counters = '0;
    logic [NB*8-1:0]   trig_fired = '0;
    logic [NR*8-1:0]   cfg_regs;
    logic              reset_hist;
    logic              reset_out;
    logic [2:0]        phase_sel;
    logic              phase_updown;
    logic              phase_step;
    logic              scanclk;

    serial_cmd_engine #(
        .NBOARDS(NB), .HIST_W(HW), .CNT_W(CW), .NREG(NR), .TIMEOUT(TO), .VERSION(VER)
    ) dut (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .histos(histos), .counters(counters), .trig_fired(trig_fired),
        .cfg_regs(cfg_regs), .reset_hist(reset_hist), .reset_out(reset_out),
        .phase_sel(phase_sel), .phase_updown(phase_updown),
        .phase_step(phase_step), .scanclk(scanclk)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rx_cyc = 0;
    int first_tx_cyc = -1;
    int busy_cnt = 0;
    int tx_len   = 0;
    bit force_busy = 1'b0;
    bit prev_start = 1'b0;
    logic prev_sclk = 1'b0;
    int hist_pulses = 0;
    int out_pulses  = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int tog_cyc[$];
    logic tog_step[$];
    logic [7:0] model_regs[NR];
    logic [55:0] cnt_arr[NB];
    logic [7:0] trig_arr[NB];

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         n;
        logic [7:0] rsp;
    } vec_t;
    vec_t vecs[14];

    assign tx_busy = force_busy || (busy_cnt > 0);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model and output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        if (tx_start === 1'b1) begin
            checkOutput("no_back_to_back_tx", {127'b0, prev_start}, 128'd0);
            if (got.size() == 0) first_tx_cyc = cyc;
            got.push_back(tx_data);
            busy_cnt = tx_len;
        end
        prev_start = (tx_start === 1'b1);
        if (reset_hist === 1'b1) hist_pulses++;
        if (reset_out === 1'b1) out_pulses++;
        if (scanclk !== prev_sclk) begin
            tog_cyc.push_back(cyc);
            tog_step.push_back(phase_step);
        end
        prev_sclk = scanclk;
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_ready    = 1'b1;
        rx_data     = b;
        last_rx_cyc = cyc + 1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic waitBytes(input int n, input int budget);
        int w = 0;
        while (got.size() < n && w < budget) begin
            @(negedge clk);
            w++;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic compareGot(input string name);
        checkOutput({name, "_len"}, 128'(got.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", name, i), {120'b0, got[i]}, {120'b0, exp_q[i]});
        end
    endtask

    task automatic sendCmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
        got.delete();
        first_tx_cyc = -1;
        applyStimulus(b0);
        if (n > 1) applyStimulus(b1);
        if (n > 2) applyStimulus(b2);
    endtask

    task automatic runCmd(input string name, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input int n, input logic [7:0] rsp);
        exp_q.delete();
        exp_q.push_back(rsp);
        sendCmd(b0, b1, b2, n);
        waitBytes(1, 3000);
        compareGot(name);
        checkOutput({name, "_latency"}, 128'(first_tx_cyc - last_rx_cyc), 128'd2);
    endtask

    function automatic logic [NR*8-1:0] modelCfg();
        logic [NR*8-1:0] v;
        for (int r = 0; r < NR; r++) v[r*8 +: 8] = model_regs[r];
        return v;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < NR; r++) model_regs[r] = 8'h00;
        model_regs[0] = 8'd20;
        model_regs[1] = 8'd50;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_start"}, {127'b0, tx_start}, 128'd0);
        checkOutput({tag, "_tx_data"}, {120'b0, tx_data}, 128'd0);
        checkOutput({tag, "_reset_hist"}, {127'b0, reset_hist}, 128'd0);
        checkOutput({tag, "_reset_out"}, {127'b0, reset_out}, 128'd0);
        checkOutput({tag, "_phase_step"}, {127'b0, phase_step}, 128'd0);
        checkOutput({tag, "_scanclk"}, {127'b0, scanclk}, 128'd0);
        checkOutput({tag, "_phase_updown"}, {127'b0, phase_updown}, 128'd1);
        checkOutput({tag, "_phase_sel"}, {125'b0, phase_sel}, 128'd0);
        checkOutput({tag, "_cfg_regs"}, cfg_regs, 128'h3214);
    endtask

    // Watchdog so the run always ends even if the DUT stalls.
    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int kind;
        logic [7:0] a, d, op;
        int n0;

        modelReset();
        vecs[0]  = '{8'h00, 8'h00, 8'h00, 1, 8'h09};
        vecs[1]  = '{8'h02, 8'h00, 8'h00, 2, 8'd20};
        vecs[2]  = '{8'h02, 8'h01, 8'h00, 2, 8'd50};
        vecs[3]  = '{8'h02, 8'h07, 8'h00, 2, 8'h00};
        vecs[4]  = '{8'h01, 8'h05, 8'hA7, 3, 8'hAC};
        vecs[5]  = '{8'h02, 8'h05, 8'h00, 2, 8'hA7};
        vecs[6]  = '{8'h02, 8'h15, 8'h00, 2, 8'hA7};
        vecs[7]  = '{8'h01, 8'h13, 8'h5A, 3, 8'hAC};
        vecs[8]  = '{8'h02, 8'h03, 8'h00, 2, 8'h5A};
        vecs[9]  = '{8'h02, 8'hF3, 8'h00, 2, 8'h5A};
        vecs[10] = '{8'h06, 8'h00, 8'h00, 1, 8'hEE};
        vecs[11] = '{8'hFF, 8'h00, 8'h00, 1, 8'hEE};
        vecs[12] = '{8'h01, 8'h00, 8'h1E, 3, 8'hAC};
        vecs[13] = '{8'h02, 8'h10, 8'h00, 2, 8'h1E};

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table of single-byte-reply commands.
        for (int i = 0; i < 14; i++) begin
            tx_len = i % 3;
            runCmd($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n, vecs[i].rsp);
            if (vecs[i].b0 == 8'h01) model_regs[vecs[i].b1 % NR] = vecs[i].b2;
        end
        checkOutput("cfg_reg5", {120'b0, cfg_regs[47:40]}, 128'hA7);
        checkOutput("cfg_after_table", cfg_regs, modelCfg());

        // Randomized commands against the register-file model.
        for (int i = 0; i < 40; i++) begin
            kind   = $urandom_range(0, 3);
            tx_len = $urandom_range(0, 3);
            a = 8'($urandom);
            d = 8'($urandom);
            case (kind)
                0: runCmd("rnd_version", 8'h00, 8'h00, 8'h00, 1, VER);
                1: begin
                    runCmd("rnd_write", 8'h01, a, d, 3, 8'hAC);
                    model_regs[a % NR] = d;
                end
                2: runCmd("rnd_read", 8'h02, a, 8'h00, 2, model_regs[a % NR]);
                default: begin
                    op = 8'($urandom_range(6, 255));
                    runCmd("rnd_bad", op, 8'h00, 8'h00, 1, 8'hEE);
                end
            endcase
        end
        checkOutput("cfg_after_random", cfg_regs, modelCfg());

        // Histogram snapshot; live inputs change mid-reply.
        for (int b = 0; b < NB; b++) histos[b*HW +: HW] = 32'h0102_0300 + b;
        exp_q.delete();
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < HW/8; k++) exp_q.push_back(8'((32'h0102_0300 + b) >> (8*k)));
        end
        tx_len = 2;
        hist_pulses = 0;
        sendCmd(8'h03, 8'h00, 8'h00, 1);
        waitBytes(4, 500);
        for (int b = 0; b < NB; b++) histos[b*HW +: HW] = $urandom;
        waitBytes(NB*HW/8, 3000);
        compareGot("hist");
        if (got.size() >= 16)
            checkOutput("hist_board3", {96'b0, got[15], got[14], got[13], got[12]}, 128'h0102_0303);
        checkOutput("reset_hist_pulses", 128'(hist_pulses), 128'd1);

        // Inter-byte timeout: discarded write, NAK, registers unchanged.
        tx_len = 1;
        exp_q.delete();
        exp_q.push_back(8'hEE);
        sendCmd(8'h01, 8'h05, 8'h00, 2);
        repeat (TO - 10) @(negedge clk);
        checkOutput("timeout_not_early", 128'(got.size()), 128'd0);
        waitBytes(1, 100);
        compareGot("timeout_nak");
        checkOutput("cfg_after_timeout", cfg_regs, modelCfg());
        runCmd("version_after_timeout", 8'h00, 8'h00, 8'h00, 1, VER);

        // Phase-step sequence.
        tog_cyc.delete();
        tog_step.delete();
        exp_q.delete();
        exp_q.push_back(8'hAC);
        sendCmd(8'h05, 8'h03, 8'h00, 3);
        waitBytes(1, 1000);
        compareGot("phase_ack");
        checkOutput("phase_sel", {125'b0, phase_sel}, 128'd3);
        checkOutput("phase_updown", {127'b0, phase_updown}, 128'd0);
        checkOutput("phase_toggles", 128'(tog_cyc.size()), 128'd8);
        for (int i = 0; i < tog_cyc.size() && i < 8; i++) begin
            if (i > 0) checkOutput($sformatf("phase_spacing%0d", i), 128'(tog_cyc[i] - tog_cyc[i-1]), 128'd16);
            checkOutput($sformatf("phase_step_after_toggle%0d", i+1), {127'b0, tog_step[i]}, (i < 5) ? 128'd1 : 128'd0);
        end
        if (tog_cyc.size() == 8)
            checkOutput("phase_reply_after_seq", 128'(first_tx_cyc > tog_cyc[7]), 128'd1);
        checkOutput("phase_scanclk_idle", {127'b0, scanclk}, 128'd0);

        // Counter snapshot under transmitter back-pressure.
        for (int b = 0; b < NB; b++) begin
            cnt_arr[b]  = 56'({$urandom, $urandom});
            trig_arr[b] = 8'($urandom);
            counters[b*CW +: CW]   = cnt_arr[b];
            trig_fired[b*8 +: 8]   = trig_arr[b];
        end
        exp_q.delete();
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < CW/8; k++) exp_q.push_back(cnt_arr[b][8*k +: 8]);
            exp_q.push_back(trig_arr[b]);
        end
        tx_len = 1;
        out_pulses = 0;
        force_busy = 1'b1;
        sendCmd(8'h04, 8'h00, 8'h00, 1);
        repeat (100) @(negedge clk);
        checkOutput("busy_holds_tx", 128'(got.size()), 128'd0);
        force_busy = 1'b0;
        waitBytes(NB*(CW/8+1), 3000);
        compareGot("cnt");
        checkOutput("reset_out_pulses", 128'(out_pulses), 128'd1);

        // Reset in the middle of a reply stream.
        tx_len = 4;
        sendCmd(8'h04, 8'h00, 8'h00, 1);
        waitBytes(5, 500);
        reset = 1'b1;
        @(negedge clk);
        checkResetValues("midreset");
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        n0 = got.size();
        repeat (150) @(negedge clk);
        checkOutput("no_tx_after_reset", 128'(got.size()), 128'(n0));
        checkOutput("cfg_after_midreset", cfg_regs, modelCfg());
        tx_len = 0;
        runCmd("version_after_reset", 8'h00, 8'h00, 8'h00, 1, VER);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
